// File: rtl/vga_axil_slave_pkg.sv
// Shared constants, FSM state types and address-map helpers for the
// VGA AXI-lite slave.
package vga_axil_slave_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  localparam int unsigned BUF_BASE    = 4096;
  localparam int unsigned BUF_LIMIT   = 6496;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP}    r_state_t;

  // Font region: below the text buffer, write-only.
  function automatic logic is_font(input logic [31:0] addr);
    return addr < BUF_BASE;
  endfunction

  // Text buffer region: readable and writable.
  function automatic logic is_buf(input logic [31:0] addr);
    return (addr >= BUF_BASE) && (addr < BUF_LIMIT);
  endfunction

endpackage

// File: rtl/vga_axil_slave_if.sv
// AXI-lite bus seen by the VGA slave; signal names match the legacy flat ports.
interface vga_axil_slave_if #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 13
);
  logic                            s_axil_awvalid_i;
  logic                            s_axil_awready_o;
  logic [C_AXI_ADDR_WIDTH-1:0]     s_axil_awaddr_i;
  logic                            s_axil_wvalid_i;
  logic                            s_axil_wready_o;
  logic [C_AXI_DATA_WIDTH-1:0]     s_axil_wdata_i;
  logic [C_AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb_i;
  logic                            s_axil_bvalid_o;
  logic                            s_axil_bready_i;
  logic [1:0]                      s_axil_bresp_o;
  logic                            s_axil_arvalid_i;
  logic                            s_axil_arready_o;
  logic [C_AXI_ADDR_WIDTH-1:0]     s_axil_araddr_i;
  logic                            s_axil_rvalid_o;
  logic                            s_axil_rready_i;
  logic [C_AXI_DATA_WIDTH-1:0]     s_axil_rdata_o;
  logic [1:0]                      s_axil_rresp_o;

  modport slave (
    input  s_axil_awvalid_i, s_axil_awaddr_i, s_axil_wvalid_i, s_axil_wdata_i,
           s_axil_wstrb_i, s_axil_bready_i, s_axil_arvalid_i, s_axil_araddr_i,
           s_axil_rready_i,
    output s_axil_awready_o, s_axil_wready_o, s_axil_bvalid_o, s_axil_bresp_o,
           s_axil_arready_o, s_axil_rvalid_o, s_axil_rdata_o, s_axil_rresp_o
  );

  modport master (
    output s_axil_awvalid_i, s_axil_awaddr_i, s_axil_wvalid_i, s_axil_wdata_i,
           s_axil_wstrb_i, s_axil_bready_i, s_axil_arvalid_i, s_axil_araddr_i,
           s_axil_rready_i,
    input  s_axil_awready_o, s_axil_wready_o, s_axil_bvalid_o, s_axil_bresp_o,
           s_axil_arready_o, s_axil_rvalid_o, s_axil_rdata_o, s_axil_rresp_o
  );
endinterface

// File: rtl/vga_axil_slave.sv
// AXI-lite slave bridging to the VGA display core: font/text-buffer writes
// become one-cycle commit pulses, text-buffer reads issue a request and
// capture the buffer data after RD_LATENCY cycles.
module vga_axil_slave
  import vga_axil_slave_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 13,
  parameter int unsigned RD_LATENCY       = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  vga_axil_slave_if.slave               s_axil,
  output logic                          axil_wready_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
  output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
  output logic                          axil_rreq_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_raddr_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axil_rdata_i
);

  localparam int unsigned STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  w_state_t                    w_state;
  r_state_t                    r_state;

  logic                        aw_held, w_held;
  logic [C_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]           wstrb_q;

  logic                        aw_hs, w_hs, aw_done, w_done, wr_ok, wr_commit;
  logic [C_AXI_ADDR_WIDTH-1:0] cur_awaddr;
  logic [C_AXI_DATA_WIDTH-1:0] cur_wdata;
  logic [STRB_W-1:0]           cur_wstrb;

  logic                        ar_hs, rreq_pending;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr_q;
  logic [CNT_W-1:0]            lat_cnt;

  // Merge held and freshly handshaken write halves; flag a commit due this edge.
  always_comb begin
    aw_hs      = s_axil.s_axil_awvalid_i & s_axil.s_axil_awready_o;
    w_hs       = s_axil.s_axil_wvalid_i  & s_axil.s_axil_wready_o;
    aw_done    = aw_held | aw_hs;
    w_done     = w_held  | w_hs;
    cur_awaddr = aw_held ? awaddr_q : s_axil.s_axil_awaddr_i;
    cur_wdata  = w_held  ? wdata_q  : s_axil.s_axil_wdata_i;
    cur_wstrb  = w_held  ? wstrb_q  : s_axil.s_axil_wstrb_i;
    wr_ok      = is_font(32'(cur_awaddr)) | is_buf(32'(cur_awaddr));
    wr_commit  = (w_state != W_RESP) && aw_done && w_done && wr_ok;
    ar_hs      = s_axil.s_axil_arvalid_i & s_axil.s_axil_arready_o;
  end

  // Write FSM: collect AW and W independently, commit once, hold B until bready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state                 <= W_IDLE;
      aw_held                 <= 1'b0;
      w_held                  <= 1'b0;
      awaddr_q                <= '0;
      wdata_q                 <= '0;
      wstrb_q                 <= '0;
      s_axil.s_axil_awready_o <= 1'b1;
      s_axil.s_axil_wready_o  <= 1'b1;
      s_axil.s_axil_bvalid_o  <= 1'b0;
      s_axil.s_axil_bresp_o   <= RESP_OKAY;
      axil_wready_o           <= 1'b0;
      axil_waddr_o            <= '0;
      axil_wdata_o            <= '0;
      axil_wstrb_o            <= '0;
    end else begin
      axil_wready_o <= 1'b0;
      case (w_state)
        W_IDLE, W_COLLECT: begin
          if (aw_hs) begin
            aw_held                 <= 1'b1;
            awaddr_q                <= s_axil.s_axil_awaddr_i;
            s_axil.s_axil_awready_o <= 1'b0;
          end
          if (w_hs) begin
            w_held                 <= 1'b1;
            wdata_q                <= s_axil.s_axil_wdata_i;
            wstrb_q                <= s_axil.s_axil_wstrb_i;
            s_axil.s_axil_wready_o <= 1'b0;
          end
          if (aw_done && w_done) begin
            w_state                <= W_RESP;
            s_axil.s_axil_bvalid_o <= 1'b1;
            s_axil.s_axil_bresp_o  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
              axil_wready_o <= 1'b1;
              axil_waddr_o  <= cur_awaddr;
              axil_wdata_o  <= cur_wdata;
              axil_wstrb_o  <= cur_wstrb;
            end
          end else if (aw_done || w_done) begin
            w_state <= W_COLLECT;
          end
        end
        W_RESP: begin
          if (s_axil.s_axil_bready_i) begin
            w_state                 <= W_IDLE;
            aw_held                 <= 1'b0;
            w_held                  <= 1'b0;
            s_axil.s_axil_bvalid_o  <= 1'b0;
            s_axil.s_axil_awready_o <= 1'b1;
            s_axil.s_axil_wready_o  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: buffer reads request and wait RD_LATENCY cycles (the request
  // cycle counts as the first); a request that would land on a commit pulse
  // is held one cycle in R_WAIT so it sees the written data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state                 <= R_IDLE;
      rreq_pending            <= 1'b0;
      araddr_q                <= '0;
      lat_cnt                 <= '0;
      s_axil.s_axil_arready_o <= 1'b1;
      s_axil.s_axil_rvalid_o  <= 1'b0;
      s_axil.s_axil_rdata_o   <= '0;
      s_axil.s_axil_rresp_o   <= RESP_OKAY;
      axil_rreq_o             <= 1'b0;
      axil_raddr_o            <= '0;
    end else begin
      axil_rreq_o <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_axil.s_axil_arready_o <= 1'b0;
            araddr_q                <= s_axil.s_axil_araddr_i;
            if (is_buf(32'(s_axil.s_axil_araddr_i))) begin
              r_state      <= R_WAIT;
              lat_cnt      <= '0;
              rreq_pending <= wr_commit;
              axil_rreq_o  <= ~wr_commit;
              axil_raddr_o <= s_axil.s_axil_araddr_i;
            end else begin
              r_state                <= R_RESP;
              s_axil.s_axil_rvalid_o <= 1'b1;
              s_axil.s_axil_rdata_o  <= '0;
              s_axil.s_axil_rresp_o  <= RESP_SLVERR;
            end
          end
        end
        R_WAIT: begin
          if (rreq_pending) begin
            if (!wr_commit) begin
              rreq_pending <= 1'b0;
              axil_rreq_o  <= 1'b1;
              axil_raddr_o <= araddr_q;
              lat_cnt      <= '0;
            end
          end else if (lat_cnt == CNT_W'(RD_LATENCY - 1)) begin
            r_state                <= R_RESP;
            s_axil.s_axil_rvalid_o <= 1'b1;
            s_axil.s_axil_rdata_o  <= axil_rdata_i;
            s_axil.s_axil_rresp_o  <= RESP_OKAY;
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        R_RESP: begin
          if (s_axil.s_axil_rready_i) begin
            r_state                 <= R_IDLE;
            s_axil.s_axil_rvalid_o  <= 1'b0;
            s_axil.s_axil_arready_o <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_axil_slave.sv
// Directed bench for vga_axil_slave: a vector table of single writes/reads
// plus hand-written sequences for split AW/W, read/write ordering and reset.
module tb_vga_axil_slave;
  import vga_axil_slave_pkg::*;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 13;
  localparam int unsigned RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          axil_wready;
  logic [AW-1:0] axil_waddr;
  logic [DW-1:0] axil_wdata;
  logic [3:0]    axil_wstrb;
  logic          axil_rreq;
  logic [AW-1:0] axil_raddr;
  logic [DW-1:0] axil_rdata = '0;

  vga_axil_slave_if #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) bus ();

  vga_axil_slave #(
    .C_AXI_DATA_WIDTH(DW),
    .C_AXI_ADDR_WIDTH(AW),
    .RD_LATENCY(RD_LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .s_axil(bus),
    .axil_wready_o(axil_wready),
    .axil_waddr_o(axil_waddr),
    .axil_wdata_o(axil_wdata),
    .axil_wstrb_o(axil_wstrb),
    .axil_rreq_o(axil_rreq),
    .axil_raddr_o(axil_raddr),
    .axil_rdata_i(axil_rdata)
  );

  always #20 clk = ~clk;

  // Display-core model: read-first buffer with data valid the cycle after
  // rreq; poison value otherwise so a mistimed capture is visible.
  logic [31:0]   mem [0:2047];
  int            cyc = 0, commit_cnt = 0, rreq_cnt = 0, coincide_cnt = 0;
  int            commit_cyc = 0, rreq_cyc = 0;
  logic [AW-1:0] last_raddr = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (axil_rreq) begin
      axil_rdata <= mem[axil_raddr[12:2]];
      rreq_cnt   = rreq_cnt + 1;
      rreq_cyc   = cyc;
      last_raddr = axil_raddr;
    end else begin
      axil_rdata <= 32'hDEADBEEF;
    end
    if (axil_wready) begin
      for (int b = 0; b < 4; b++)
        if (axil_wstrb[b]) mem[axil_waddr[12:2]][8*b +: 8] = axil_wdata[8*b +: 8];
      commit_cnt = commit_cnt + 1;
      commit_cyc = cyc;
    end
    if (axil_wready && axil_rreq) coincide_cnt = coincide_cnt + 1;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic ok);
    int base;
    base = commit_cnt;
    chk("awready_idle", 32'(bus.s_axil_awready_o), 1);
    chk("wready_idle", 32'(bus.s_axil_wready_o), 1);
    bus.s_axil_awvalid_i = 1'b1; bus.s_axil_awaddr_i = a;
    bus.s_axil_wvalid_i  = 1'b1; bus.s_axil_wdata_i  = d; bus.s_axil_wstrb_i = s;
    step();
    bus.s_axil_awvalid_i = 1'b0; bus.s_axil_wvalid_i = 1'b0;
    chk("wr_commit", 32'(axil_wready), 32'(ok));
    if (ok) begin
      chk("wr_addr", 32'(axil_waddr), 32'(a));
      chk("wr_data", axil_wdata, d);
      chk("wr_strb", 32'(axil_wstrb), 32'(s));
    end
    chk("bvalid", 32'(bus.s_axil_bvalid_o), 1);
    chk("bresp", 32'(bus.s_axil_bresp_o), ok ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
    chk("awready_busy", 32'(bus.s_axil_awready_o), 0);
    chk("wready_busy", 32'(bus.s_axil_wready_o), 0);
    bus.s_axil_bready_i = 1'b1;
    step();
    bus.s_axil_bready_i = 1'b0;
    chk("bvalid_clear", 32'(bus.s_axil_bvalid_o), 0);
    chk("awready_back", 32'(bus.s_axil_awready_o), 1);
    chk("wready_back", 32'(bus.s_axil_wready_o), 1);
    chk("commit_count", 32'(commit_cnt - base), 32'(ok));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic ok, input logic [31:0] d);
    int base, lat;
    base = rreq_cnt;
    chk("arready_idle", 32'(bus.s_axil_arready_o), 1);
    bus.s_axil_arvalid_i = 1'b1; bus.s_axil_araddr_i = a;
    step();
    bus.s_axil_arvalid_i = 1'b0;
    chk("arready_busy", 32'(bus.s_axil_arready_o), 0);
    lat = 1;
    while (!bus.s_axil_rvalid_o && lat < 20) begin
      step();
      lat++;
    end
    chk("rd_latency", 32'(lat), ok ? 32'(RD_LAT + 1) : 32'd1);
    chk("rvalid", 32'(bus.s_axil_rvalid_o), 1);
    chk("rdata", bus.s_axil_rdata_o, ok ? d : 32'h0);
    chk("rresp", 32'(bus.s_axil_rresp_o), ok ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
    chk("rreq_count", 32'(rreq_cnt - base), 32'(ok));
    if (ok) chk("rreq_addr", 32'(last_raddr), 32'(a));
    step();
    chk("rvalid_hold", 32'(bus.s_axil_rvalid_o), 1);
    chk("rdata_hold", bus.s_axil_rdata_o, ok ? d : 32'h0);
    bus.s_axil_rready_i = 1'b1;
    step();
    bus.s_axil_rready_i = 1'b0;
    chk("rvalid_clear", 32'(bus.s_axil_rvalid_o), 0);
    chk("arready_back", 32'(bus.s_axil_arready_o), 1);
  endtask

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
    logic          ok;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int base, lat;

    vecs[0]  = '{1'b1, 13'h1000, 32'h41424344, 4'hF, 1'b1};
    vecs[1]  = '{1'b1, 13'h1004, 32'h11223344, 4'hF, 1'b1};
    vecs[2]  = '{1'b1, 13'h0010, 32'hA5A5A5A5, 4'h3, 1'b1};
    vecs[3]  = '{1'b1, 13'h1960, 32'hDEADDEAD, 4'hF, 1'b0};
    vecs[4]  = '{1'b1, 13'h195C, 32'hCAFEF00D, 4'hF, 1'b1};
    vecs[5]  = '{1'b1, 13'h1010, 32'hFFFFFFFF, 4'hF, 1'b1};
    vecs[6]  = '{1'b1, 13'h1010, 32'h00000000, 4'h6, 1'b1};
    vecs[7]  = '{1'b1, 13'h1FFC, 32'h12345678, 4'hF, 1'b0};
    vecs[8]  = '{1'b0, 13'h1004, 32'h11223344, 4'h0, 1'b1};
    vecs[9]  = '{1'b0, 13'h1000, 32'h41424344, 4'h0, 1'b1};
    vecs[10] = '{1'b0, 13'h195C, 32'hCAFEF00D, 4'h0, 1'b1};
    vecs[11] = '{1'b0, 13'h1010, 32'hFF0000FF, 4'h0, 1'b1};
    vecs[12] = '{1'b0, 13'h0020, 32'h00000000, 4'h0, 1'b0};
    vecs[13] = '{1'b0, 13'h1960, 32'h00000000, 4'h0, 1'b0};
    vecs[14] = '{1'b0, 13'h0FFC, 32'h00000000, 4'h0, 1'b0};

    bus.s_axil_awvalid_i = 1'b0; bus.s_axil_awaddr_i = '0;
    bus.s_axil_wvalid_i  = 1'b0; bus.s_axil_wdata_i  = '0; bus.s_axil_wstrb_i = '0;
    bus.s_axil_bready_i  = 1'b0;
    bus.s_axil_arvalid_i = 1'b0; bus.s_axil_araddr_i = '0;
    bus.s_axil_rready_i  = 1'b0;

    // Reset values
    repeat (3) step();
    rst = 1'b0;
    chk("rst_awready", 32'(bus.s_axil_awready_o), 1);
    chk("rst_wready", 32'(bus.s_axil_wready_o), 1);
    chk("rst_arready", 32'(bus.s_axil_arready_o), 1);
    chk("rst_bvalid", 32'(bus.s_axil_bvalid_o), 0);
    chk("rst_rvalid", 32'(bus.s_axil_rvalid_o), 0);
    chk("rst_commit", 32'(axil_wready), 0);
    chk("rst_rreq", 32'(axil_rreq), 0);
    chk("rst_waddr", 32'(axil_waddr), 0);
    chk("rst_wdata", axil_wdata, 0);
    chk("rst_rdata", bus.s_axil_rdata_o, 0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].ok);
      else               do_read(vecs[i].addr, vecs[i].ok, vecs[i].data);
    end

    // W one cycle ahead of AW
    base = commit_cnt;
    bus.s_axil_wvalid_i = 1'b1; bus.s_axil_wdata_i = 32'h0BADF00D; bus.s_axil_wstrb_i = 4'hF;
    step();
    bus.s_axil_wvalid_i = 1'b0;
    chk("split_wready_low", 32'(bus.s_axil_wready_o), 0);
    chk("split_awready_high", 32'(bus.s_axil_awready_o), 1);
    chk("split_no_early_commit", 32'(axil_wready), 0);
    chk("split_no_early_b", 32'(bus.s_axil_bvalid_o), 0);
    bus.s_axil_awvalid_i = 1'b1; bus.s_axil_awaddr_i = 13'h0010;
    step();
    bus.s_axil_awvalid_i = 1'b0;
    chk("split_commit", 32'(axil_wready), 1);
    chk("split_waddr", 32'(axil_waddr), 32'h0010);
    chk("split_wdata", axil_wdata, 32'h0BADF00D);
    chk("split_bresp", 32'(bus.s_axil_bresp_o), 32'(RESP_OKAY));
    step();
    chk("split_wready_still_low", 32'(bus.s_axil_wready_o), 0);
    chk("split_bvalid_held", 32'(bus.s_axil_bvalid_o), 1);
    bus.s_axil_bready_i = 1'b1;
    step();
    bus.s_axil_bready_i = 1'b0;
    chk("split_wready_back", 32'(bus.s_axil_wready_o), 1);
    chk("split_one_commit", 32'(commit_cnt - base), 1);

    // Read launched with a committing write to the same word
    bus.s_axil_awvalid_i = 1'b1; bus.s_axil_awaddr_i = 13'h1000;
    bus.s_axil_wvalid_i  = 1'b1; bus.s_axil_wdata_i  = 32'h5A5A1234; bus.s_axil_wstrb_i = 4'hF;
    bus.s_axil_arvalid_i = 1'b1; bus.s_axil_araddr_i = 13'h1000;
    step();
    bus.s_axil_awvalid_i = 1'b0; bus.s_axil_wvalid_i = 1'b0; bus.s_axil_arvalid_i = 1'b0;
    chk("order_commit", 32'(axil_wready), 1);
    chk("order_rreq_deferred", 32'(axil_rreq), 0);
    bus.s_axil_bready_i = 1'b1;
    step();
    bus.s_axil_bready_i = 1'b0;
    chk("order_rreq_issued", 32'(axil_rreq), 1);
    lat = 2;
    while (!bus.s_axil_rvalid_o && lat < 20) begin
      step();
      lat++;
    end
    chk("order_latency", 32'(lat), 32'(RD_LAT + 2));
    chk("order_rdata", bus.s_axil_rdata_o, 32'h5A5A1234);
    chk("order_rreq_after_commit", 32'(rreq_cyc - commit_cyc), 1);
    chk("order_no_coincide", 32'(coincide_cnt), 0);
    bus.s_axil_rready_i = 1'b1;
    step();
    bus.s_axil_rready_i = 1'b0;

    // B held under bready=0, then reset during a buffer read
    bus.s_axil_awvalid_i = 1'b1; bus.s_axil_awaddr_i = 13'h1014;
    bus.s_axil_wvalid_i  = 1'b1; bus.s_axil_wdata_i  = 32'h00000077; bus.s_axil_wstrb_i = 4'hF;
    step();
    bus.s_axil_awvalid_i = 1'b0; bus.s_axil_wvalid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        bus.s_axil_arvalid_i = 1'b1; bus.s_axil_araddr_i = 13'h1000;
      end
      chk("bhold_bvalid", 32'(bus.s_axil_bvalid_o), 1);
      chk("bhold_bresp", 32'(bus.s_axil_bresp_o), 32'(RESP_OKAY));
      step();
      if (i == 3) bus.s_axil_arvalid_i = 1'b0;
    end
    chk("midread_no_rvalid", 32'(bus.s_axil_rvalid_o), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = commit_cnt;
    chk("abort_bvalid", 32'(bus.s_axil_bvalid_o), 0);
    chk("abort_rvalid", 32'(bus.s_axil_rvalid_o), 0);
    chk("abort_awready", 32'(bus.s_axil_awready_o), 1);
    chk("abort_wready", 32'(bus.s_axil_wready_o), 1);
    chk("abort_arready", 32'(bus.s_axil_arready_o), 1);
    chk("abort_rdata", bus.s_axil_rdata_o, 0);
    chk("abort_rreq", 32'(axil_rreq), 0);
    repeat (4) step();
    chk("abort_no_commit", 32'(commit_cnt - base), 0);
    chk("abort_still_no_rvalid", 32'(bus.s_axil_rvalid_o), 0);
    chk("abort_still_no_bvalid", 32'(bus.s_axil_bvalid_o), 0);
    do_read(13'h1014, 1'b1, 32'h00000077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
